// File: rtl/uart_cmd_if.sv
// Byte stream from the UART receiver in, register-bus strobes and status out.
// The parser uses the slave modport; whatever feeds it bytes uses master.
interface uart_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic       cmd_err;
  logic       busy;

  modport master (
    output rx_data, rx_valid, rx_err,
    input  reg_addr, reg_wdata, reg_we, reg_re, cmd_err, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_err,
    output reg_addr, reg_wdata, reg_we, reg_re, cmd_err, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses ASCII hex frames "Waadd<CR>" / "Raa<CR>" from a UART byte stream into register-bus strobes.
// Define UART_CMD_LOWERCASE_EN to also accept 'w', 'r' and 'a'-'f'.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  uart_cmd_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AH   = 3'd1;
  localparam logic [2:0] S_AL   = 3'd2;
  localparam logic [2:0] S_DH   = 3'd3;
  localparam logic [2:0] S_DL   = 3'd4;
  localparam logic [2:0] S_TERM = 3'd5;
  localparam logic [2:0] S_SKIP = 3'd6;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam int            CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Returns {valid, nibble}.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46)
      return {1'b1, c[3:0] + 4'd9};
`ifdef UART_CMD_LOWERCASE_EN
    else if (c >= 8'h61 && c <= 8'h66)
      return {1'b1, c[3:0] + 4'd9};
`endif
    else
      return 5'd0;
  endfunction

  logic [2:0]    r_state;
  logic          r_wr;
  logic [7:0]    r_addr_sh;
  logic [7:0]    r_data_sh;
  logic [7:0]    r_addr;
  logic [7:0]    r_wdata;
  logic          r_we;
  logic          r_re;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic          r_valid_q;
  logic          r_err_q;

  logic          w_vstb;
  logic          w_estb;
  logic [4:0]    w_nib;
  logic          w_is_w;
  logic          w_is_r;
  logic          w_syn;
  logic [2:0]    w_state_next;
  logic          w_wr_next;
  logic [7:0]    w_addr_sh_next;
  logic [7:0]    w_data_sh_next;
  logic [7:0]    w_addr_next;
  logic [7:0]    w_wdata_next;
  logic          w_we_next;
  logic          w_re_next;
  logic          w_err_next;

  assign w_vstb = bus.rx_valid & ~r_valid_q;
  assign w_estb = bus.rx_err & ~r_err_q;
  assign w_nib  = hex_nib(bus.rx_data);

`ifdef UART_CMD_LOWERCASE_EN
  assign w_is_w = (bus.rx_data == 8'h57) || (bus.rx_data == 8'h77);
  assign w_is_r = (bus.rx_data == 8'h52) || (bus.rx_data == 8'h72);
`else
  assign w_is_w = (bus.rx_data == 8'h57);
  assign w_is_r = (bus.rx_data == 8'h52);
`endif

  always_comb begin
    w_state_next   = r_state;
    w_wr_next      = r_wr;
    w_addr_sh_next = r_addr_sh;
    w_data_sh_next = r_data_sh;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_we_next      = 1'b0;
    w_re_next      = 1'b0;
    w_err_next     = 1'b0;
    w_syn          = 1'b0;

    // A framing error masks any byte that rose in the same cycle.
    if (w_estb) begin
      if (r_state != S_SKIP) begin
        w_err_next   = 1'b1;
        w_state_next = S_SKIP;
      end
    end else if (w_vstb) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_w) begin
            w_state_next = S_AH;
            w_wr_next    = 1'b1;
          end else if (w_is_r) begin
            w_state_next = S_AH;
            w_wr_next    = 1'b0;
          end else if (bus.rx_data != CH_CR && bus.rx_data != CH_LF) begin
            w_syn = 1'b1;
          end
        end
        S_AH: begin
          if (w_nib[4]) begin
            w_addr_sh_next[7:4] = w_nib[3:0];
            w_state_next        = S_AL;
          end else begin
            w_syn = 1'b1;
          end
        end
        S_AL: begin
          if (w_nib[4]) begin
            w_addr_sh_next[3:0] = w_nib[3:0];
            w_state_next        = r_wr ? S_DH : S_TERM;
          end else begin
            w_syn = 1'b1;
          end
        end
        S_DH: begin
          if (w_nib[4]) begin
            w_data_sh_next[7:4] = w_nib[3:0];
            w_state_next        = S_DL;
          end else begin
            w_syn = 1'b1;
          end
        end
        S_DL: begin
          if (w_nib[4]) begin
            w_data_sh_next[3:0] = w_nib[3:0];
            w_state_next        = S_TERM;
          end else begin
            w_syn = 1'b1;
          end
        end
        S_TERM: begin
          if (bus.rx_data == CH_CR) begin
            w_state_next = S_IDLE;
            w_addr_next  = r_addr_sh;
            if (r_wr) begin
              w_wdata_next = r_data_sh;
              w_we_next    = 1'b1;
            end else begin
              w_re_next = 1'b1;
            end
          end else begin
            w_syn = 1'b1;
          end
        end
        S_SKIP: begin
          if (bus.rx_data == CH_CR)
            w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase

      // A stray CR already terminates the line, so there is nothing left to skip.
      if (w_syn) begin
        w_err_next   = 1'b1;
        w_state_next = (bus.rx_data == CH_CR) ? S_IDLE : S_SKIP;
      end
    end else if (r_state != S_IDLE && r_cnt == TO_LAST) begin
      w_state_next = S_IDLE;
      w_err_next   = (r_state != S_SKIP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr      <= 1'b0;
      r_addr_sh <= 8'h00;
      r_data_sh <= 8'h00;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      // Held high so a level already present at reset release is not a new byte.
      r_valid_q <= 1'b1;
      r_err_q   <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_wr      <= w_wr_next;
      r_addr_sh <= w_addr_sh_next;
      r_data_sh <= w_data_sh_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_we      <= w_we_next;
      r_re      <= w_re_next;
      r_err     <= w_err_next;
      r_valid_q <= bus.rx_valid;
      r_err_q   <= bus.rx_err;
      if (r_state == S_IDLE || w_vstb || w_estb)
        r_cnt <= '0;
      else if (r_cnt != TO_LAST)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_we    = r_we;
  assign bus.reg_re    = r_re;
  assign bus.cmd_err   = r_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: vector table, hand-written corner sequences,
// and randomized frames checked against a character-level reference model.
module tb_uart_cmd_parser;

  localparam int T = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_cmd_if bus();

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_we = 0, cnt_re = 0, cnt_err = 0;
  int cyc = 0;
  int ev_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_we) cnt_we++;
      if (bus.reg_re) cnt_re++;
      if (bus.cmd_err) cnt_err++;
      if ((int'(bus.reg_we) + int'(bus.reg_re) + int'(bus.cmd_err)) > 1) begin
        n_checks++;
        n_errors++;
        $display("FAIL strobe_exclusive: got we=%0b re=%0b err=%0b, required at most one high",
                 bus.reg_we, bus.reg_re, bus.cmd_err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // One receiver event: rises valid and/or err, samples outputs one clock later, checks width.
  task automatic send_ev(input logic [7:0] b, input bit v, input bit e,
                         output logic [2:0] s, output logic [7:0] a, output logic [7:0] d,
                         output logic bz);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = v;
    bus.rx_err   = e;
    @(posedge clk); #1;
    s  = {bus.reg_we, bus.reg_re, bus.cmd_err};
    a  = bus.reg_addr;
    d  = bus.reg_wdata;
    bz = bus.busy;
    ev_cyc = cyc;
    @(posedge clk); #1;
    chk("pulse_width", {29'd0, bus.reg_we, bus.reg_re, bus.cmd_err}, 32'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [2:0] s);
    logic [7:0] a, d;
    logic bz;
    send_ev(b, 1'b1, 1'b0, s, a, d, bz);
  endtask

  // ---------------- reference model (character-level) ----------------
  localparam int M_IDLE = 0, M_FRAME = 1, M_SKIP = 2;
  int         m_mode;
  logic [7:0] m_addr, m_wdata;
  logic [7:0] m_frame[$];

  function automatic bit is_hex(input logic [7:0] c);
    if (c inside {[8'h30:8'h39], [8'h41:8'h46]}) return 1'b1;
`ifdef UART_CMD_LOWERCASE_EN
    if (c inside {[8'h61:8'h66]}) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [7:0] lc;
    if (c <= 8'h39) return 4'(c - 8'h30);
    lc = c | 8'h20;
    return 4'(lc - 8'h61 + 8'd10);
  endfunction

  // Number of characters in a frame before its CR, or 0 if not a command letter.
  function automatic int cmd_len(input logic [7:0] c);
    if (c == 8'h57) return 5;
    if (c == 8'h52) return 3;
`ifdef UART_CMD_LOWERCASE_EN
    if (c == 8'h77) return 5;
    if (c == 8'h72) return 3;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_addr  = 8'h00;
    m_wdata = 8'h00;
    m_frame.delete();
  endtask

  task automatic model_ev(input logic [7:0] b, input bit v, input bit e, output logic [2:0] s);
    int len;
    bit bad;
    s   = 3'b000;
    bad = 1'b0;
    if (e) begin
      if (m_mode != M_SKIP) begin
        s      = 3'b001;
        m_mode = M_SKIP;
      end
    end else if (v) begin
      case (m_mode)
        M_IDLE: begin
          if (cmd_len(b) != 0) begin
            m_frame.delete();
            m_frame.push_back(b);
            m_mode = M_FRAME;
          end else if (b != 8'h0D && b != 8'h0A) begin
            bad = 1'b1;
          end
        end
        M_FRAME: begin
          len = cmd_len(m_frame[0]);
          if (m_frame.size() < len) begin
            if (is_hex(b)) m_frame.push_back(b);
            else bad = 1'b1;
          end else if (b == 8'h0D) begin
            m_addr = {hex_val(m_frame[1]), hex_val(m_frame[2])};
            if (len == 5) begin
              m_wdata = {hex_val(m_frame[3]), hex_val(m_frame[4])};
              s = 3'b100;
            end else begin
              s = 3'b010;
            end
            m_mode = M_IDLE;
          end else begin
            bad = 1'b1;
          end
        end
        default: if (b == 8'h0D) m_mode = M_IDLE;
      endcase
      if (bad) begin
        s      = 3'b001;
        m_mode = (b == 8'h0D) ? M_IDLE : M_SKIP;
      end
    end
  endtask

  function automatic logic [7:0] rand_hex();
    int v;
    v = $urandom_range(0, 15);
    if (v < 10) return 8'(48 + v);
    if ($urandom_range(0, 3) == 0) return 8'(87 + v);
    return 8'(55 + v);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [47:0] txt;
    int          n;
    int          we;
    int          re;
    int          err;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        busy;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic [2:0] s, es;
    logic [7:0] a, d, la, ld, ch;
    logic bz;
    int w0, r0, e0, fired, delta;
    logic [9:0] q[$];
    int kind, pos;

    bus.rx_data  = 8'h57;
    bus.rx_valid = 1'b1;
    bus.rx_err   = 1'b1;

    // Reset state, with both receiver levels already high across release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", {24'd0, bus.reg_addr}, 32'h00);
    chk("rst_wdata", {24'd0, bus.reg_wdata}, 32'h00);
    chk("rst_strobes", {29'd0, bus.reg_we, bus.reg_re, bus.cmd_err}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("held_level_busy", {31'd0, bus.busy}, 32'd0);
    chk("held_level_pulses", cnt_we + cnt_re + cnt_err, 32'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
    repeat (2) @(negedge clk);

`ifdef UART_CMD_LOWERCASE_EN
    la = 8'h1A; ld = 8'hFF;
`else
    la = 8'h01; ld = 8'hA5;
`endif
    tv[0]  = '{"W3CA5\r", 6, 1, 0, 0, 8'h3C, 8'hA5, 1'b0};
    tv[1]  = '{"R7F\r",   4, 0, 1, 0, 8'h7F, 8'hA5, 1'b0};
    tv[2]  = '{"W3G",     3, 0, 0, 1, 8'h7F, 8'hA5, 1'b1};
    tv[3]  = '{"12\r",    3, 0, 0, 0, 8'h7F, 8'hA5, 1'b0};
    tv[4]  = '{"R01\r",   4, 0, 1, 0, 8'h01, 8'hA5, 1'b0};
`ifdef UART_CMD_LOWERCASE_EN
    tv[5]  = '{"w1aff\r", 6, 1, 0, 0, 8'h1A, 8'hFF, 1'b0};
`else
    tv[5]  = '{"w1aff\r", 6, 0, 0, 1, 8'h01, 8'hA5, 1'b0};
`endif
    tv[6]  = '{"\n\r",    2, 0, 0, 0, la,    ld,    1'b0};
    tv[7]  = '{"W12\r",   4, 0, 0, 1, la,    ld,    1'b0};
    tv[8]  = '{"R10\r",   4, 0, 1, 0, 8'h10, ld,    1'b0};
    tv[9]  = '{"X\r",     2, 0, 0, 1, 8'h10, ld,    1'b0};
    tv[10] = '{"W00FF\r", 6, 1, 0, 0, 8'h00, 8'hFF, 1'b0};
    tv[11] = '{"R5A5\r",  5, 0, 0, 1, 8'h00, 8'hFF, 1'b0};

    for (int i = 0; i < 12; i++) begin
      w0 = cnt_we; r0 = cnt_re; e0 = cnt_err;
      for (int k = 0; k < tv[i].n; k++) begin
        ch = tv[i].txt[8*(tv[i].n-1-k) +: 8];
        send_byte(ch, s);
      end
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_we", i), cnt_we - w0, tv[i].we);
      chk($sformatf("vec%0d_re", i), cnt_re - r0, tv[i].re);
      chk($sformatf("vec%0d_err", i), cnt_err - e0, tv[i].err);
      chk($sformatf("vec%0d_addr", i), {24'd0, bus.reg_addr}, {24'd0, tv[i].addr});
      chk($sformatf("vec%0d_wdata", i), {24'd0, bus.reg_wdata}, {24'd0, tv[i].wdata});
      chk($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, {31'd0, tv[i].busy});
    end

    // rx_err rising mid "R5": error pulse, then SKIP swallows bytes and further errors until CR.
    send_byte(8'h52, s);
    send_byte(8'h35, s);
    send_ev(8'h00, 1'b0, 1'b1, s, a, d, bz);
    chk("estb_pulse", {29'd0, s}, 32'b001);
    chk("estb_busy", {31'd0, bz}, 32'd1);
    send_ev(8'h00, 1'b0, 1'b1, s, a, d, bz);
    chk("estb_in_skip", {29'd0, s}, 32'd0);
    send_byte(8'h31, s);
    chk("skip_discard", {29'd0, s}, 32'd0);
    send_ev(8'h0D, 1'b1, 1'b0, s, a, d, bz);
    chk("skip_cr_strobes", {29'd0, s}, 32'd0);
    chk("skip_cr_busy", {31'd0, bz}, 32'd0);

    // Valid and error rising together: error wins, byte discarded.
    send_byte(8'h57, s);
    send_byte(8'h31, s);
    send_ev(8'h32, 1'b1, 1'b1, s, a, d, bz);
    chk("both_strobe", {29'd0, s}, 32'b001);
    w0 = cnt_we; e0 = cnt_err;
    send_byte(8'h33, s);
    send_byte(8'h34, s);
    send_byte(8'h0D, s);
    chk("both_no_we", cnt_we - w0, 32'd0);
    chk("both_no_err", cnt_err - e0, 32'd0);

    // Inter-byte timeout inside a frame.
    send_byte(8'h57, s);
    send_byte(8'h31, s);
    send_byte(8'h32, s);
    e0 = cnt_err;
    fired = -1;
    for (int i = 0; i < 3 * T && fired < 0; i++) begin
      @(posedge clk); #1;
      if (bus.cmd_err) fired = cyc - ev_cyc;
    end
    chk("timeout_fired", (fired >= T - 2 && fired <= T + 1) ? 32'd1 : 32'd0, 32'd1);
    repeat (T) @(posedge clk);
    #1;
    chk("timeout_once", cnt_err - e0, 32'd1);
    chk("timeout_busy", {31'd0, bus.busy}, 32'd0);
    w0 = cnt_we;
    send_byte(8'h57, s); send_byte(8'h30, s); send_byte(8'h31, s);
    send_byte(8'h30, s); send_byte(8'h32, s); send_byte(8'h0D, s);
    chk("after_to_we", cnt_we - w0, 32'd1);
    chk("after_to_addr", {24'd0, bus.reg_addr}, 32'h01);
    chk("after_to_wdata", {24'd0, bus.reg_wdata}, 32'h02);

    // Timeout while skipping is silent.
    send_byte(8'h58, s);
    chk("junk_err", {29'd0, s}, 32'b001);
    e0 = cnt_err;
    repeat (3 * T) @(posedge clk);
    #1;
    chk("skip_to_silent", cnt_err - e0, 32'd0);
    chk("skip_to_busy", {31'd0, bus.busy}, 32'd0);

    // Reset mid-frame abandons the frame and clears the bus outputs.
    send_byte(8'h57, s);
    send_byte(8'h31, s);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_addr", {24'd0, bus.reg_addr}, 32'h00);
    chk("midrst_wdata", {24'd0, bus.reg_wdata}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    w0 = cnt_we;
    send_byte(8'h52, s); send_byte(8'h32, s); send_byte(8'h32, s);
    send_ev(8'h0D, 1'b1, 1'b0, s, a, d, bz);
    m_addr = 8'h22;
    chk("midrst_re", {29'd0, s}, 32'b010);
    chk("midrst_re_addr", {24'd0, a}, 32'h22);
    chk("midrst_no_we", cnt_we - w0, 32'd0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 150; f++) begin
      q.delete();
      kind = $urandom_range(0, 9);
      ch = ($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52;
      if ($urandom_range(0, 3) == 0) ch = ch | 8'h20;
      q.push_back({2'b10, ch});
      for (int k = 0; k < ((ch[4:0] == 5'h17) ? 4 : 2); k++) q.push_back({2'b10, rand_hex()});
      q.push_back({2'b10, 8'h0D});
      if (kind == 6 || kind == 7) begin
        pos = $urandom_range(0, q.size() - 1);
        q[pos] = {2'b10, 8'($urandom_range(0, 255))};
      end else if (kind == 8) begin
        pos = $urandom_range(0, q.size() - 1);
        q.insert(pos, {2'b10, 8'($urandom_range(0, 255))});
      end else if (kind == 9) begin
        pos = $urandom_range(0, q.size() - 1);
        q.insert(pos, {($urandom_range(0, 1) != 0), 1'b1, rand_hex()});
        q.push_back({2'b10, 8'h0D});
      end
      foreach (q[k]) begin
        send_ev(q[k][7:0], q[k][9], q[k][8], s, a, d, bz);
        model_ev(q[k][7:0], q[k][9], q[k][8], es);
        chk("rand_strobes", {29'd0, s}, {29'd0, es});
        chk("rand_busy", {31'd0, bz}, (m_mode != M_IDLE) ? 32'd1 : 32'd0);
        if (es[2] || es[1]) begin
          chk("rand_addr", {24'd0, a}, {24'd0, m_addr});
          chk("rand_wdata", {24'd0, d}, {24'd0, m_wdata});
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
